// File: rtl/ahb_lite_slave.sv
// rtl/ahb_lite_slave.sv - AHB-Lite slave with zero-wait word memory and two-cycle ERROR response
module ahb_lite_slave #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

  localparam logic [1:0] IDLE_DP = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
  localparam logic [1:0] ERR1    = 2'd2;
  localparam logic [1:0] ERR2    = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   offset;
  logic          sample, size_ok, align_ok, range_ok, legal;
  logic [3:0]    be_nxt, dp_be;
  logic          dp_write;
  logic [AW-1:0] dp_idx;
  logic          unused_ok;

  // Bursts are handled as independent singles, so HBURST and the SEQ/NONSEQ distinction carry no meaning here.
  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign offset   = HADDR - BASE_ADDR;
  assign sample   = HREADY && HTRANS[1];
  assign size_ok  = (HSIZE <= 3'b010);
  assign range_ok = (offset < MEM_BYTES);
  assign legal    = size_ok && align_ok && range_ok;

  always_comb begin
    align_ok = 1'b1;
    be_nxt   = 4'b1111;
    case (HSIZE)
      3'b000: be_nxt = 4'b0001 << HADDR[1:0];
      3'b001: begin
        align_ok = !HADDR[0];
        be_nxt   = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: align_ok = (HADDR[1:0] == 2'b00);
      default: be_nxt = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = IDLE_DP;
    if (state == ERR1)
      state_nxt = ERR2;
    else if (sample)
      state_nxt = legal ? DATA : ERR1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE_DP;
      dp_write <= 1'b0;
      dp_be    <= 4'b0000;
      dp_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (sample && legal) begin
        dp_write <= HWRITE;
        dp_be    <= be_nxt;
        dp_idx   <= offset[AW+1:2];
      end
    end
  end

  // Write lands on the edge closing the data phase, so a read issued right behind it sees the new word.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else if (state == DATA && dp_write) begin
      for (int b = 0; b < 4; b++)
        if (dp_be[b])
          mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

  assign HREADY = (state != ERR1);
  assign HRESP  = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
  assign HRDATA = (state == DATA && !dp_write) ? mem[dp_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_slave.sv
// tb/tb_ahb_lite_slave.sv - scoreboard bench for ahb_lite_slave with directed and random transfers
module tb_ahb_lite_slave;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;

  logic        HCLK, HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  ahb_lite_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] pend_wdata;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One expected response per clock; the monitor consumes them in bus order.
  always @(negedge HCLK) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow at %0t: got %b/%b/%h, expected an entry", $time, HREADY, HRESP, HRDATA);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("resp@%0t {hready,hresp,hrdata}", $time),
              {HREADY, HRESP, HRDATA}, {mon_e.rdy, mon_e.resp, mon_e.data});
      end
    end
  end

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
    longint off;
    int     nb;
    if (sz > 3'd2) return 1'b0;
    nb = 1 << sz;
    if ((a % nb) != 0) return 1'b0;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (off >= 0) && (off < 4 * DEPTH);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) begin
      logic [31:0] ba;
      logic [31:0] w;
      ba = a + 32'(k);
      w  = (ba - BASE) / 4;
      mem_m[w][ba[1:0]*8 +: 8] = wd[ba[1:0]*8 +: 8];
    end
  endfunction

  function automatic void push_exp(input logic rdy, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    e.rdy  = rdy;
    e.resp = resp;
    e.data = data;
    sb.push_back(e);
  endfunction

  // Called at posedge+1: drives one address phase plus the previous transfer's write data.
  task automatic issue(input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    bit lg;
    HTRANS = tr;
    HWRITE = wr;
    HSIZE  = sz;
    HADDR  = a;
    HBURST = 3'($urandom_range(0, 7));
    HWDATA = pend_wdata;
    lg = tr[1] && is_legal(a, sz);
    if (!tr[1]) begin
      push_exp(1'b1, 2'b00, 32'h0);
      pend_wdata = $urandom;
    end else if (lg) begin
      if (wr) begin
        model_write(a, sz, wd);
        push_exp(1'b1, 2'b00, 32'h0);
        pend_wdata = wd;
      end else begin
        push_exp(1'b1, 2'b00, mem_m[(a - BASE) >> 2]);
        pend_wdata = $urandom;
      end
    end else begin
      push_exp(1'b0, 2'b01, 32'h0);
      push_exp(1'b1, 2'b01, 32'h0);
      pend_wdata = $urandom;
    end
    @(posedge HCLK); #1;
    if (tr[1] && !lg) begin
      // Junk write during the wait state must be ignored.
      HTRANS = T_NSEQ;
      HWRITE = 1'b1;
      HSIZE  = SZ_W;
      HADDR  = $urandom_range(0, 63) * 4;
      HWDATA = $urandom;
      @(posedge HCLK); #1;
    end
  endtask

  task automatic start_mon();
    push_exp(1'b1, 2'b00, 32'h0);
    mon_en = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
  endtask

  initial begin
    HRESETn = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HSIZE = SZ_W;
    HADDR = 32'h0; HWDATA = 32'h0; HBURST = 3'b000; pend_wdata = 32'h0;
    clear_model();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hready", 64'(HREADY), 64'd1);
    check("rst_hresp",  64'(HRESP),  64'd0);
    check("rst_hrdata", 64'(HRDATA), 64'd0);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    start_mon();

    // Reset asserted in the middle of a read data phase.
    issue(T_NSEQ, 1, SZ_W, 32'h10, 32'hA5A5_5A5A);
    issue(T_NSEQ, 0, SZ_W, 32'h10, 32'h0);
    mon_en = 1'b0;
    sb.delete();
    HTRANS = T_IDLE;
    #1 check("pre_rst_hrdata", 64'(HRDATA), 64'hA5A5_5A5A);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_hready", 64'(HREADY), 64'd1);
    check("mid_rst_hresp",  64'(HRESP),  64'd0);
    check("mid_rst_hrdata", 64'(HRDATA), 64'd0);
    clear_model();
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    start_mon();
    issue(T_NSEQ, 0, SZ_W, 32'h10, 32'h0);

    issue(T_NSEQ, 1, SZ_W, 32'h4, 32'hDEAD_BEEF);
    issue(T_NSEQ, 0, SZ_W, 32'h4, 32'h0);

    issue(T_NSEQ, 1, SZ_W, 32'h8, 32'h0000_0000);
    issue(T_NSEQ, 1, SZ_B, 32'h9, 32'h0000_AB00);
    issue(T_NSEQ, 1, SZ_H, 32'hA, 32'h1234_0000);
    issue(T_NSEQ, 0, SZ_W, 32'h8, 32'h0);

    issue(T_NSEQ, 1, SZ_W, 32'h100, 32'd1);
    issue(T_SEQ,  1, SZ_W, 32'h104, 32'd2);
    issue(T_BUSY, 1, SZ_W, 32'h108, 32'd0);
    issue(T_SEQ,  1, SZ_W, 32'h108, 32'd3);
    issue(T_SEQ,  1, SZ_W, 32'h10C, 32'd4);
    issue(T_NSEQ, 0, SZ_W, 32'h100, 32'h0);
    issue(T_SEQ,  0, SZ_W, 32'h104, 32'h0);
    issue(T_SEQ,  0, SZ_W, 32'h108, 32'h0);
    issue(T_SEQ,  0, SZ_W, 32'h10C, 32'h0);

    issue(T_NSEQ, 1, SZ_W, 32'h2, 32'hFFFF_FFFF);
    issue(T_NSEQ, 0, SZ_W, 32'h0, 32'h0);
    issue(T_NSEQ, 1, SZ_W, 32'(4 * DEPTH), 32'h1111_2222);
    issue(T_NSEQ, 1, 3'b011, 32'h4, 32'h3333_4444);
    issue(T_NSEQ, 0, SZ_W, 32'h4, 32'h0);
    issue(T_NSEQ, 0, SZ_W, 32'(4 * DEPTH - 4), 32'h0);

    issue(T_NSEQ, 0, SZ_W, 32'h4, 32'h0);
    issue(T_IDLE, 0, SZ_W, 32'h4, 32'h0);
    issue(T_IDLE, 0, SZ_W, 32'h4, 32'h0);
    issue(T_NSEQ, 0, SZ_W, 32'h4, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] a;
      int          r;
      r  = $urandom_range(0, 9);
      tr = (r < 1) ? T_IDLE : (r < 2) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
      sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = ($urandom_range(0, 19) == 0) ? 32'(4 * DEPTH - 8 + $urandom_range(0, 15))
                                        : 32'($urandom_range(0, 127));
      issue(tr, bit'($urandom_range(0, 1)), sz, a, $urandom);
    end

    HTRANS = T_IDLE;
    HWDATA = pend_wdata;
    @(negedge HCLK); #1;
    mon_en = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
